// File: rtl/fft8_pkg.sv
// fft8_pkg: shared types, sizes and helpers for the 8-point FFT pipeline
package fft8_pkg;
    typedef struct packed {
        logic signed [31:0] re;
        logic signed [31:0] im;
    } cplx32_t;

    typedef enum logic [1:0] {TW_ONE, TW_NJ, TW_W1, TW_W3} tw_sel_t;

    localparam int N           = 8;
    localparam int SAMPLE_W    = 8;
    localparam int ACC_W       = 32;
    localparam int TWIDDLE_Q15 = 23170;

    function automatic logic [2:0] bitrev3(input logic [2:0] i);
        return {i[0], i[1], i[2]};
    endfunction
endpackage

// File: rtl/fft8_bfly.sv
// fft8_bfly: combinational radix-2 butterfly y0 = a + W*b, y1 = a - W*b
// Ports:
//   tw  in   twiddle select: 1, -j, W8^1 = (T,-T), W8^3 = (-T,-T)
//   a   in   upper input (complex, 32b re/im)
//   b   in   lower input, multiplied by the twiddle
//   y0  out  a + W*b
//   y1  out  a - W*b
module fft8_bfly import fft8_pkg::*; #(
    parameter int TWIDDLE = 23170
) (
    input  tw_sel_t tw,
    input  cplx32_t a,
    input  cplx32_t b,
    output cplx32_t y0,
    output cplx32_t y1
);
    localparam logic signed [15:0] T = 16'(TWIDDLE);

    logic signed [47:0] pr, pi, acc_re, acc_im;
    logic signed [31:0] t_re, t_im;

    assign pr = 48'(b.re) * 48'(T);
    assign pi = 48'(b.im) * 48'(T);

    // Both diagonal twiddles have |re| = |im| = T, so two products serve both;
    // the Q15 result is floored by the arithmetic shift, then truncated to 32b.
    always_comb begin
        acc_re = tw == TW_W1 ? pr + pi : pi - pr;
        acc_im = tw == TW_W1 ? pi - pr : -(pr + pi);
        t_re   = tw == TW_ONE ? b.re : tw == TW_NJ ? b.im  : 32'(acc_re >>> 15);
        t_im   = tw == TW_ONE ? b.im : tw == TW_NJ ? -b.re : 32'(acc_im >>> 15);
    end

    assign y0 = {a.re + t_re, a.im + t_im};
    assign y1 = {a.re - t_re, a.im - t_im};
endmodule

// File: rtl/axis_fft_8point_dft.sv
// axis_fft_8point_dft: 8-point radix-2 DIT FFT, 8 real int8 samples in, 8 complex 32b bins out
// Ports:
//   s_axis_aclk    in   clock
//   s_axis_areset  in   synchronous active-high reset (valid/tlast pipe and skid only)
//   s_axis_tvalid  in   input beat valid
//   s_axis_tready  out  input beat accepted when tvalid & tready
//   s_axis_tdata   in   x[k] = tdata[8k+7:8k], signed
//   s_axis_tlast   in   frame marker, travels with its data
//   m_axis_tvalid  out  output beat valid
//   m_axis_tready  in   downstream ready
//   m_axis_tdata   out  bin k at [64k+63:64k] = {re, im}, signed 32b each
//   m_axis_tlast   out  delayed tlast
//   m_axis_tkeep   out  all ones
// Define FFT8_SKID_EN to add a 2-entry output skid buffer that registers s_axis_tready.
module axis_fft_8point_dft #(
    parameter int C_AXIS_TDATA_WIDTH = 64,
    parameter int C_AXIS_TOUT_WIDTH  = 512,
    parameter int TWIDDLE_Q15        = 23170
) (
    input  logic                          s_axis_aclk,
    input  logic                          s_axis_areset,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    input  logic [C_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                          s_axis_tlast,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic [C_AXIS_TOUT_WIDTH-1:0]  m_axis_tdata,
    output logic                          m_axis_tlast,
    output logic [C_AXIS_TOUT_WIDTH/8-1:0] m_axis_tkeep
);
    import fft8_pkg::*;

    logic [C_AXIS_TDATA_WIDTH-1:0] x_q;
    cplx32_t a [N], b1 [N], b2 [N], b3 [N];
    cplx32_t s1 [N], s2 [N], s3 [N];
    logic [C_AXIS_TOUT_WIDTH-1:0] pk;
    logic [3:0] v, l;
    logic en;

    // Inputs enter in bit-reversed order so the last stage emits natural order.
    for (genvar k = 0; k < N; k++) begin : g_io
        localparam int SRC = int'(bitrev3(3'(k)));
        assign a[k] = {{(ACC_W-SAMPLE_W){x_q[SAMPLE_W*SRC+SAMPLE_W-1]}},
                       x_q[SAMPLE_W*SRC +: SAMPLE_W], ACC_W'(0)};
        assign pk[2*ACC_W*k +: 2*ACC_W] = s3[k];
    end

    for (genvar p = 0; p < 4; p++) begin : g_bf
        localparam int I2 = 4*(p/2) + p%2;
        localparam tw_sel_t TW2 = p%2 == 1 ? TW_NJ : TW_ONE;
        localparam tw_sel_t TW3 = p == 0 ? TW_ONE : p == 1 ? TW_W1 : p == 2 ? TW_NJ : TW_W3;
        fft8_bfly #(.TWIDDLE(TWIDDLE_Q15)) u_st1 (
            .tw(TW_ONE), .a(a[2*p]), .b(a[2*p+1]), .y0(b1[2*p]), .y1(b1[2*p+1]));
        fft8_bfly #(.TWIDDLE(TWIDDLE_Q15)) u_st2 (
            .tw(TW2), .a(s1[I2]), .b(s1[I2+2]), .y0(b2[I2]), .y1(b2[I2+2]));
        fft8_bfly #(.TWIDDLE(TWIDDLE_Q15)) u_st3 (
            .tw(TW3), .a(s2[p]), .b(s2[p+4]), .y0(b3[p]), .y1(b3[p+4]));
    end

    always_ff @(posedge s_axis_aclk) begin
        if (en) begin
            x_q <= s_axis_tdata;
            s1  <= b1;
            s2  <= b2;
            s3  <= b3;
        end
    end

    always_ff @(posedge s_axis_aclk) begin
        if (s_axis_areset) begin
            v <= '0;
            l <= '0;
        end else if (en) begin
            v <= {v[2:0], s_axis_tvalid};
            l <= {l[2:0], s_axis_tlast};
        end
    end

    assign m_axis_tkeep = '1;

`ifdef FFT8_SKID_EN
    logic [C_AXIS_TOUT_WIDTH:0] mem [2];
    logic wp, rp, push, pop;
    logic [1:0] cnt;

    // The pipeline only advances while the buffer has room, so a beat leaving
    // stage 3 always has a free slot and tready depends on registers only.
    assign en            = ~cnt[1];
    assign s_axis_tready = ~cnt[1];
    assign push          = v[3] & en;
    assign pop           = m_axis_tvalid & m_axis_tready;
    assign m_axis_tvalid = cnt != 2'd0;
    assign {m_axis_tlast, m_axis_tdata} = mem[rp];

    always_ff @(posedge s_axis_aclk) begin
        if (push) mem[wp] <= {l[3], pk};
    end

    always_ff @(posedge s_axis_aclk) begin
        if (s_axis_areset) begin
            wp  <= 1'b0;
            rp  <= 1'b0;
            cnt <= 2'd0;
        end else begin
            wp  <= wp ^ push;
            rp  <= rp ^ pop;
            cnt <= cnt + 2'(push) - 2'(pop);
        end
    end
`else
    assign en            = ~v[3] | m_axis_tready;
    assign s_axis_tready = en;
    assign m_axis_tvalid = v[3];
    assign m_axis_tdata  = pk;
    assign m_axis_tlast  = l[3];
`endif
endmodule

// File: tb/tb_axis_fft_8point_dft.sv
// tb_axis_fft_8point_dft: directed-vector bench for axis_fft_8point_dft
`timescale 1ns/1ps
module tb_axis_fft_8point_dft;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic s_tvalid = 1'b0, s_tlast = 1'b0, m_tready = 1'b1;
    logic [63:0] s_tdata = '0;
    logic s_tready, m_tvalid, m_tlast;
    logic [511:0] m_tdata;
    logic [63:0] m_tkeep;
    int checks = 0;
    int errors = 0;

`ifdef FFT8_SKID_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif

    always #5 clk = ~clk;

    axis_fft_8point_dft dut (
        .s_axis_aclk(clk),
        .s_axis_areset(rst),
        .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready),
        .s_axis_tdata(s_tdata),
        .s_axis_tlast(s_tlast),
        .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_tready),
        .m_axis_tdata(m_tdata),
        .m_axis_tlast(m_tlast),
        .m_axis_tkeep(m_tkeep)
    );

    localparam logic [63:0] VIN [7] = '{
        64'h0000_0000_0000_0001,
        64'h0101_0101_0101_0101,
        64'hFF01_FF01_FF01_FF01,
        64'h0000_0000_0000_4000,
        64'h0000_0000_4000_0000,
        64'h0000_0000_0000_0080,
        64'h7F7F_7F7F_7F7F_7F7F
    };
    localparam int EXP_RE [7][8] = '{
        '{1, 1, 1, 1, 1, 1, 1, 1},
        '{8, 0, 0, 0, 0, 0, 0, 0},
        '{0, 0, 0, 0, 8, 0, 0, 0},
        '{64, 45, 0, -46, -64, -45, 0, 46},
        '{64, -46, 0, 45, -64, 46, 0, -45},
        '{-128, -128, -128, -128, -128, -128, -128, -128},
        '{1016, 0, 0, 0, 0, 0, 0, 0}
    };
    localparam int EXP_IM [7][8] = '{
        '{0, 0, 0, 0, 0, 0, 0, 0},
        '{0, 0, 0, 0, 0, 0, 0, 0},
        '{0, 0, 0, 0, 0, 0, 0, 0},
        '{0, -46, -64, -46, 0, 46, 64, 46},
        '{0, -46, 64, -46, 0, 46, -64, 46},
        '{0, 0, 0, 0, 0, 0, 0, 0},
        '{0, 0, 0, 0, 0, 0, 0, 0}
    };

    function automatic int re_of(input logic [511:0] d, input int k);
        return d[64*k+32 +: 32];
    endfunction

    function automatic int im_of(input logic [511:0] d, input int k);
        return d[64*k +: 32];
    endfunction

    // Called just after a rising edge with the DUT idle; returns edges from accept to output.
    task automatic run_beat(input logic [63:0] d, input logic tl,
                            output int lat, output logic [511:0] q, output logic ql);
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tlast  = tl;
        @(posedge clk); #1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        lat = 0;
        while (!m_tvalid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        q  = m_tdata;
        ql = m_tlast;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        m_tready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %b want 0", m_tvalid); end
        checks++; if (m_tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast got %b want 0", m_tlast); end
        checks++; if (s_tready !== 1'b1) begin errors++; $display("FAIL reset_tready got %b want 1", s_tready); end
        checks++; if (m_tkeep !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL reset_tkeep got %h want all ones", m_tkeep); end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (s_tready !== 1'b1) begin errors++; $display("FAIL post_reset_tready got %b want 1", s_tready); end
        checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL post_reset_tvalid got %b want 0", m_tvalid); end
    endtask

    task automatic test_transforms;
        int lat;
        logic [511:0] q;
        logic ql;
        for (int v = 0; v < 7; v++) begin
            run_beat(VIN[v], v[0], lat, q, ql);
            checks++; if (lat !== LAT) begin errors++; $display("FAIL vec%0d latency got %0d want %0d", v, lat, LAT); end
            checks++; if (ql !== v[0]) begin errors++; $display("FAIL vec%0d tlast got %b want %b", v, ql, v[0]); end
            for (int k = 0; k < 8; k++) begin
                checks++;
                if (re_of(q, k) !== EXP_RE[v][k]) begin
                    errors++; $display("FAIL vec%0d X%0d_re got %0d want %0d", v, k, re_of(q, k), EXP_RE[v][k]);
                end
                checks++;
                if (im_of(q, k) !== EXP_IM[v][k]) begin
                    errors++; $display("FAIL vec%0d X%0d_im got %0d want %0d", v, k, im_of(q, k), EXP_IM[v][k]);
                end
            end
        end
    endtask

    // Ten impulses of amplitude 1..10, downstream stalled on cycles 3-7.
    task automatic test_backpressure;
        int sent = 0, rcv = 0, extra = 0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            m_tready = !(cyc >= 3 && cyc <= 7);
            s_tvalid = sent < 10;
            s_tdata  = 64'(sent + 1);
            s_tlast  = sent == 9;
            #1;
            if (m_tvalid && m_tready) begin
                if (rcv >= 10) extra++;
                else begin
                    checks++;
                    if (re_of(m_tdata, 0) !== rcv + 1 || re_of(m_tdata, 5) !== rcv + 1 || im_of(m_tdata, 2) !== 0) begin
                        errors++; $display("FAIL bp_beat%0d X0_re got %0d want %0d", rcv, re_of(m_tdata, 0), rcv + 1);
                    end
                    checks++;
                    if (m_tlast !== (rcv == 9)) begin
                        errors++; $display("FAIL bp_tlast%0d got %b want %b", rcv, m_tlast, rcv == 9);
                    end
                    rcv++;
                end
            end
`ifndef FFT8_SKID_EN
            if (m_tvalid && !m_tready) begin
                checks++;
                if (s_tready !== 1'b0) begin errors++; $display("FAIL bp_stall_tready cyc%0d got %b want 0", cyc, s_tready); end
            end
`endif
            if (s_tvalid && s_tready) sent++;
            @(posedge clk); #1;
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        m_tready = 1'b1;
        checks++; if (sent !== 10) begin errors++; $display("FAIL bp_sent got %0d want 10", sent); end
        checks++; if (rcv !== 10) begin errors++; $display("FAIL bp_received got %0d want 10", rcv); end
        checks++; if (extra !== 0) begin errors++; $display("FAIL bp_duplicates got %0d want 0", extra); end
    endtask

    task automatic test_reset_midstream;
        int lat, seen = 0;
        logic [511:0] q;
        logic ql;
        for (int i = 0; i < 3; i++) begin
            s_tvalid = 1'b1;
            s_tdata  = 64'(50 + i);
            s_tlast  = 1'b1;
            @(posedge clk); #1;
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL midrst_tvalid got %b want 0", m_tvalid); end
        checks++; if (m_tlast !== 1'b0) begin errors++; $display("FAIL midrst_tlast got %b want 0", m_tlast); end
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (m_tvalid) seen++;
            @(posedge clk); #1;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL midrst_ghost_beats got %0d want 0", seen); end
        run_beat(64'h09, 1'b0, lat, q, ql);
        checks++; if (lat !== LAT) begin errors++; $display("FAIL midrst_latency got %0d want %0d", lat, LAT); end
        checks++; if (re_of(q, 3) !== 9) begin errors++; $display("FAIL midrst_X3_re got %0d want 9", re_of(q, 3)); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset;
        test_transforms;
        test_backpressure;
        test_reset_midstream;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
